gc_block_manager: RTL and testbench
===================================

# gc_block_manager

Parametrised garbage-collection block manager for the NVM flash translation layer. It keeps a circular FIFO of erased (free) blocks and a saturating invalid-page counter per block. When the free pool drops below a low-water mark, it sequentially scans the counters for the dirtiest block. It then hands that victim to the page-move/erase engine and returns the block to the free FIFO on acknowledge. It sits between the FTL write allocator and the erase controller.

## Interface
Parameters:
- BLOCK_NUM, 16: physical blocks; BLOCK_W = $clog2(BLOCK_NUM)
- PAGE_NUM, 64: pages per block; PAGE_W = $clog2(PAGE_NUM+1)
- FIFO_DEPTH, 8: free-FIFO entries, power of two, 2..BLOCK_NUM; CNT_W = $clog2(FIFO_DEPTH+1)
- GC_LOW, 2: GC triggers when free_cnt < GC_LOW; must satisfy 1 <= GC_LOW < FIFO_DEPTH

Ports:
- CLK  in  1  clock
- nRST  in  1  reset: nRST, asynchronous, active-low; clock CLK
- init_start  in  1  pulse: start pool initialisation
- ready  out  1  initialisation complete
- alloc_req  in  1  pop the head free block
- alloc_ok  out  1  FIFO non-empty and ready
- alloc_blk  out  BLOCK_W  current FIFO head
- recover_en  in  1  push recover_blk back, e.g. after an aborted allocation
- recover_blk  in  BLOCK_W  block to return
- recover_err  out  1  pulse: recover dropped
- inval_en  in  1  one page of inval_blk invalidated
- inval_blk  in  BLOCK_W  block holding the invalidated page
- open_blk  in  BLOCK_W  block currently being written; never chosen as victim
- gc_force  in  1  start a scan regardless of the low-water mark
- victim_valid  out  1  victim presented
- victim_blk  out  BLOCK_W  victim block
- victim_ack  in  1  victim moved and erased
- gc_busy  out  1  state is SCAN or VICTIM
- gc_fail  out  1  pulse: scan found no candidate
- free_cnt  out  CNT_W  FIFO occupancy

## Operation
- States: UNINIT, INIT, IDLE, SCAN, VICTIM.
- UNINIT (reset state):
  - alloc_ok = 0.
  - init_start -> INIT.
- INIT:
  - Pushes blocks 0, 1, … , min(BLOCK_NUM, FIFO_DEPTH)-1, one per cycle.
  - Clears all invalid counters.
  - alloc, recover and inval are ignored.
  - After the last push -> IDLE and ready = 1.
  - init_start outside UNINIT is ignored.
- IDLE:
  - (free_cnt < GC_LOW or gc_force) -> SCAN.
  - The scan index is reset to 0, best_cnt to 0 and best_blk to 0.
- SCAN:
  - Visits one index per cycle for BLOCK_NUM cycles.
  - A visited block replaces the best when its counter > best_cnt and index != open_blk.
  - Ties resolve to the lowest index.
  - The counter value used is the registered value at visit time.
  - After index BLOCK_NUM-1: best_cnt > 0 -> VICTIM; otherwise gc_fail pulses for 1 cycle -> IDLE.
- VICTIM:
  - victim_valid = 1, with victim_blk held stable.
  - On victim_ack: the victim's counter is cleared, the victim is pushed to the FIFO, then -> IDLE.
- Counters:
  - inval_en increments counter[inval_blk], saturating at PAGE_NUM.
  - A clear on victim_ack for the same block in the same cycle wins over the increment.
- FIFO:
  - head/tail pointers wrap modulo FIFO_DEPTH.
  - Pop when alloc_req && alloc_ok.
- Push arbitration, at most one push per cycle:
  - INIT fill has first priority.
  - victim_ack push comes next.
  - recover push comes last.
- recover_err pulses (the push is dropped) when:
  - the FIFO is full with no simultaneous pop, or
  - the state is VICTIM, because that slot is reserved for the victim, or
  - a victim_ack push occurs in the same cycle.
- A push and a pop in the same cycle are legal when the FIFO is full or non-empty; occupancy is unchanged.

## Timing
- Reset values:
  - Outputs: all 0; alloc_blk = 0; state UNINIT.
  - Internal state: counters, pointers and free_cnt all 0.
- alloc_blk and alloc_ok are combinational from registered FIFO state; a pop is visible the next cycle.
- INIT takes min(BLOCK_NUM, FIFO_DEPTH) cycles; ready rises the cycle after the last push.
- Trigger to victim_valid: 1 cycle (IDLE->SCAN) + BLOCK_NUM cycles.
- Ack to block poppable and free_cnt updated: 1 cycle.
- An inval landing on a block after its visit does not affect the current scan.
- nRST is asserted asynchronously mid-operation: everything returns to UNINIT and the pool must be re-initialised.

## Structure
- Shared package nvm_pkg holds:
  - block_t and page_t typedefs sized from BLOCK_NUM and PAGE_NUM
  - gc_state_t enum
  - BLOCK_W and PAGE_W constants
- Sub-module free_block_fifo (parametrised depth/width, push/pop/full/empty/count) instantiated once.
- Counters, scan datapath and FSM live in the top level.

## Test plan
- init_start with defaults -> 8 pushes over 8 cycles; ready = 1; free_cnt = 8; alloc_blk = 0; pop order 0..7.
- Pop 7 blocks -> free_cnt = 1 triggers SCAN.
  - With 5 invals to block 3, 5 to block 9, and open_blk = 12: victim_blk = 3 after 17 cycles.
  - On ack: block 3 pushed, counter[3] = 0.
- 70 invals to block 4 -> counter saturates at 64; a same-cycle ack of block 4 with an inval leaves the counter at 0.
- gc_force with all counters 0 -> gc_fail pulses once, returns to IDLE, victim_valid never asserted.
- Push/pop corner cases:
  - FIFO full, recover_en without alloc -> recover_err, free_cnt unchanged.
  - Full, recover + alloc_req together -> accepted.
  - During VICTIM, recover -> recover_err.
- Assert nRST during SCAN -> all outputs 0, state UNINIT, alloc_ok = 0 until a new init_start.

Source files
------------

// File: rtl/nvm_pkg.sv
// Shared FTL types: default geometry, block/page index types and the GC state encoding.
package nvm_pkg;

    localparam int BLOCK_NUM = 16;
    localparam int PAGE_NUM  = 64;
    localparam int BLOCK_W   = $clog2(BLOCK_NUM);
    localparam int PAGE_W    = $clog2(PAGE_NUM + 1);

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [PAGE_W-1:0]  page_t;

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_INIT,
        ST_IDLE,
        ST_SCAN,
        ST_VICTIM
    } gc_state_t;

endpackage

// File: rtl/gc_block_manager_if.sv
// Allocator / erase-engine facing signal bundle of the GC block manager.
interface gc_block_manager_if #(
    parameter int BLOCK_W = 4,
    parameter int CNT_W   = 4
);
    logic               init_start;
    logic               ready;
    logic               alloc_req;
    logic               alloc_ok;
    logic [BLOCK_W-1:0] alloc_blk;
    logic               recover_en;
    logic [BLOCK_W-1:0] recover_blk;
    logic               recover_err;
    logic               inval_en;
    logic [BLOCK_W-1:0] inval_blk;
    logic [BLOCK_W-1:0] open_blk;
    logic               gc_force;
    logic               victim_valid;
    logic [BLOCK_W-1:0] victim_blk;
    logic               victim_ack;
    logic               gc_busy;
    logic               gc_fail;
    logic [CNT_W-1:0]   free_cnt;

    modport slave (
        input  init_start, alloc_req, recover_en, recover_blk, inval_en, inval_blk,
               open_blk, gc_force, victim_ack,
        output ready, alloc_ok, alloc_blk, recover_err, victim_valid, victim_blk,
               gc_busy, gc_fail, free_cnt
    );

    modport master (
        output init_start, alloc_req, recover_en, recover_blk, inval_en, inval_blk,
               open_blk, gc_force, victim_ack,
        input  ready, alloc_ok, alloc_blk, recover_err, victim_valid, victim_blk,
               gc_busy, gc_fail, free_cnt
    );
endinterface

// File: rtl/gc_block_manager_fifo.sv
// Circular FIFO of free block numbers; power-of-two depth so pointers wrap naturally.
module free_block_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[head_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: storage is reset too, so the head reads block 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= tail_q + 1'b1;
            end
            if (do_pop) head_q <= head_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/gc_block_manager.sv
// GC block manager: free-block pool, per-block invalid-page counters and victim scan FSM.
module gc_block_manager #(
    parameter int BLOCK_NUM  = nvm_pkg::BLOCK_NUM,
    parameter int PAGE_NUM   = nvm_pkg::PAGE_NUM,
    parameter int FIFO_DEPTH = 8,
    parameter int GC_LOW     = 2
) (
    input logic                CLK,
    input logic                nRST,
    gc_block_manager_if.slave  bus
);
    localparam int BLOCK_W = $clog2(BLOCK_NUM);
    localparam int PAGE_W  = $clog2(PAGE_NUM + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int INIT_N  = (BLOCK_NUM < FIFO_DEPTH) ? BLOCK_NUM : FIFO_DEPTH;

    localparam logic [BLOCK_W-1:0] INIT_LAST = BLOCK_W'(INIT_N - 1);
    localparam logic [BLOCK_W-1:0] SCAN_LAST = BLOCK_W'(BLOCK_NUM - 1);
    localparam logic [PAGE_W-1:0]  PAGE_MAX  = PAGE_W'(PAGE_NUM);
    localparam logic [CNT_W-1:0]   LOW_MARK  = CNT_W'(GC_LOW);

    nvm_pkg::gc_state_t state_q, state_d;

    logic [BLOCK_W-1:0] init_idx_q, scan_idx_q, best_blk_q;
    logic [PAGE_W-1:0]  best_cnt_q;
    logic [PAGE_W-1:0]  inval_cnt_q [BLOCK_NUM];

    logic               ready, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BLOCK_W-1:0] fifo_din, fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               ack_push, recover_ok, recover_err, gc_fail;
    logic [PAGE_W-1:0]  visit_cnt, final_cnt;
    logic               take;

    assign ready     = (state_q == nvm_pkg::ST_IDLE) || (state_q == nvm_pkg::ST_SCAN) ||
                       (state_q == nvm_pkg::ST_VICTIM);
    assign fifo_pop  = bus.alloc_req && ready && !fifo_empty;
    assign ack_push  = (state_q == nvm_pkg::ST_VICTIM) && bus.victim_ack;
    // The VICTIM state reserves the single push slot for the returning victim.
    assign recover_ok  = ready && bus.recover_en && (state_q != nvm_pkg::ST_VICTIM) &&
                         (!fifo_full || fifo_pop);
    assign recover_err = ready && bus.recover_en && !recover_ok;

    assign visit_cnt = inval_cnt_q[scan_idx_q];
    assign take      = (visit_cnt > best_cnt_q) && (scan_idx_q != bus.open_blk);
    assign final_cnt = take ? visit_cnt : best_cnt_q;

    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '0;
        if (state_q == nvm_pkg::ST_INIT) begin
            fifo_push = 1'b1;
            fifo_din  = init_idx_q;
        end else if (ack_push) begin
            fifo_push = 1'b1;
            fifo_din  = best_blk_q;
        end else if (recover_ok) begin
            fifo_push = 1'b1;
            fifo_din  = bus.recover_blk;
        end
    end

    free_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLOCK_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= nvm_pkg::ST_UNINIT;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gc_fail = 1'b0;
        case (state_q)
            nvm_pkg::ST_UNINIT: if (bus.init_start) state_d = nvm_pkg::ST_INIT;
            nvm_pkg::ST_INIT:   if (init_idx_q == INIT_LAST) state_d = nvm_pkg::ST_IDLE;
            nvm_pkg::ST_IDLE:   if ((fifo_count < LOW_MARK) || bus.gc_force) state_d = nvm_pkg::ST_SCAN;
            nvm_pkg::ST_SCAN: begin
                if (scan_idx_q == SCAN_LAST) begin
                    if (final_cnt != '0) begin
                        state_d = nvm_pkg::ST_VICTIM;
                    end else begin
                        gc_fail = 1'b1;
                        state_d = nvm_pkg::ST_IDLE;
                    end
                end
            end
            nvm_pkg::ST_VICTIM: if (bus.victim_ack) state_d = nvm_pkg::ST_IDLE;
            default:            state_d = nvm_pkg::ST_UNINIT;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            init_idx_q <= '0;
            scan_idx_q <= '0;
            best_blk_q <= '0;
            best_cnt_q <= '0;
        end else begin
            init_idx_q <= (state_q == nvm_pkg::ST_INIT) ? init_idx_q + 1'b1 : '0;
            if (state_q == nvm_pkg::ST_IDLE) begin
                scan_idx_q <= '0;
                best_blk_q <= '0;
                best_cnt_q <= '0;
            end else if (state_q == nvm_pkg::ST_SCAN) begin
                scan_idx_q <= scan_idx_q + 1'b1;
                if (take) begin
                    best_blk_q <= scan_idx_q;
                    best_cnt_q <= visit_cnt;
                end
            end
        end
    end

    // Clearing the acknowledged victim outranks a same-cycle invalidation of that block.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BLOCK_NUM; i++) inval_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < BLOCK_NUM; i++) begin
                if (state_q == nvm_pkg::ST_INIT) begin
                    inval_cnt_q[i] <= '0;
                end else if (ack_push && (best_blk_q == BLOCK_W'(i))) begin
                    inval_cnt_q[i] <= '0;
                end else if (ready && bus.inval_en && (bus.inval_blk == BLOCK_W'(i)) &&
                             (inval_cnt_q[i] != PAGE_MAX)) begin
                    inval_cnt_q[i] <= inval_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.ready        = ready;
    assign bus.alloc_ok     = ready && !fifo_empty;
    assign bus.alloc_blk    = fifo_dout;
    assign bus.recover_err  = recover_err;
    assign bus.victim_valid = (state_q == nvm_pkg::ST_VICTIM);
    assign bus.victim_blk   = (state_q == nvm_pkg::ST_VICTIM) ? best_blk_q : '0;
    assign bus.gc_busy      = (state_q == nvm_pkg::ST_SCAN) || (state_q == nvm_pkg::ST_VICTIM);
    assign bus.gc_fail      = gc_fail;
    assign bus.free_cnt     = fifo_count;
endmodule

// File: tb/tb_gc_block_manager.sv
// Scoreboard bench for gc_block_manager: directed stimulus queues expectations, a monitor consumes them.
module tb_gc_block_manager;
    localparam int BW = nvm_pkg::BLOCK_W;
    localparam int CW = $clog2(8 + 1);

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    gc_block_manager_if #(.BLOCK_W(BW), .CNT_W(CW)) bus ();

    gc_block_manager #(
        .BLOCK_NUM  (16),
        .PAGE_NUM   (64),
        .FIFO_DEPTH (8),
        .GC_LOW     (2)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int exp_alloc[$];
    int exp_victim[$];
    int exp_rerr[$];
    int exp_fail[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_victim(input int max_cycles);
        int n = 0;
        while (!bus.victim_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("victim_wait", int'(bus.victim_valid), 1);
    endtask

    task automatic ack_victim(input logic with_inval, input nvm_pkg::block_t inval_b);
        bus.victim_ack = 1'b1;
        bus.inval_en   = with_inval;
        bus.inval_blk  = inval_b;
        tick();
        bus.victim_ack = 1'b0;
        bus.inval_en   = 1'b0;
    endtask

    task automatic force_scan_expect(input int blk);
        exp_victim.push_back(blk);
        bus.gc_force = 1'b1;
        tick();
        bus.gc_force = 1'b0;
        wait_victim(40);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},    int'(bus.ready), 0);
        check({tag, "_alloc_ok"}, int'(bus.alloc_ok), 0);
        check({tag, "_alloc_blk"}, int'(bus.alloc_blk), 0);
        check({tag, "_free_cnt"}, int'(bus.free_cnt), 0);
        check({tag, "_victim_valid"}, int'(bus.victim_valid), 0);
        check({tag, "_victim_blk"}, int'(bus.victim_blk), 0);
        check({tag, "_gc_busy"},  int'(bus.gc_busy), 0);
    endtask

    // Monitor: consumes one expectation per presented DUT event.
    initial begin
        logic prev_vv;
        prev_vv = 1'b0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                prev_vv = 1'b0;
            end else begin
                if (bus.alloc_req && bus.alloc_ok) begin
                    check("alloc_pending", int'(exp_alloc.size() > 0), 1);
                    if (exp_alloc.size() > 0) check("alloc_blk", int'(bus.alloc_blk), exp_alloc.pop_front());
                end
                if (bus.victim_valid && !prev_vv) begin
                    check("victim_pending", int'(exp_victim.size() > 0), 1);
                    if (exp_victim.size() > 0) check("victim_blk", int'(bus.victim_blk), exp_victim.pop_front());
                end
                if (bus.recover_err) begin
                    check("rerr_pending", int'(exp_rerr.size() > 0), 1);
                    if (exp_rerr.size() > 0) check("rerr_blk", int'(bus.recover_blk), exp_rerr.pop_front());
                end
                if (bus.gc_fail) begin
                    check("gc_fail_pending", int'(exp_fail.size() > 0), 1);
                    if (exp_fail.size() > 0) void'(exp_fail.pop_front());
                end
                prev_vv = bus.victim_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.init_start  = 1'b0;
        bus.alloc_req   = 1'b0;
        bus.recover_en  = 1'b0;
        bus.recover_blk = '0;
        bus.inval_en    = 1'b0;
        bus.inval_blk   = '0;
        bus.open_blk    = BW'(12);
        bus.gc_force    = 1'b0;
        bus.victim_ack  = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        nRST = 1'b1;
        tick();

        // Pool initialisation: eight pushes, ready the cycle after the last.
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        repeat (7) tick();
        check("init_ready_early", int'(bus.ready), 0);
        check("init_cnt7", int'(bus.free_cnt), 7);
        tick();
        check("init_ready", int'(bus.ready), 1);
        check("init_free_cnt", int'(bus.free_cnt), 8);
        check("init_alloc_blk", int'(bus.alloc_blk), 0);
        check("init_alloc_ok", int'(bus.alloc_ok), 1);

        bus.inval_en  = 1'b1;
        bus.inval_blk = BW'(3);
        repeat (5) tick();
        bus.inval_blk = BW'(9);
        repeat (5) tick();
        bus.inval_blk = BW'(12);
        repeat (10) tick();
        bus.inval_en  = 1'b0;

        // Drain to one free block: low-water scan starts by itself.
        for (int i = 0; i < 7; i++) exp_alloc.push_back(i);
        bus.alloc_req = 1'b1;
        repeat (7) tick();
        bus.alloc_req = 1'b0;
        check("pop7_free_cnt", int'(bus.free_cnt), 1);
        exp_victim.push_back(3);
        repeat (16) tick();
        check("scan_busy", int'(bus.gc_busy), 1);
        check("scan_no_victim_yet", int'(bus.victim_valid), 0);
        tick();
        check("victim_at_17", int'(bus.victim_valid), 1);

        exp_rerr.push_back(15);
        bus.recover_en  = 1'b1;
        bus.recover_blk = BW'(15);
        tick();
        bus.recover_en  = 1'b0;
        check("victim_rec_free_cnt", int'(bus.free_cnt), 1);
        check("victim_hold_blk", int'(bus.victim_blk), 3);

        ack_victim(1'b0, '0);
        check("ack1_free_cnt", int'(bus.free_cnt), 2);
        check("ack1_idle", int'(bus.gc_busy), 0);
        check("ack1_alloc_blk", int'(bus.alloc_blk), 7);

        // Block 3 was cleared on ack, so the next dirtiest is 9.
        force_scan_expect(9);
        ack_victim(1'b0, '0);
        check("ack2_free_cnt", int'(bus.free_cnt), 3);

        // Both blocks saturate at 64; the tie goes to the lower index.
        bus.inval_en  = 1'b1;
        bus.inval_blk = BW'(2);
        repeat (64) tick();
        bus.inval_blk = BW'(4);
        repeat (70) tick();
        bus.inval_en  = 1'b0;
        force_scan_expect(2);
        ack_victim(1'b0, '0);
        check("ack3_free_cnt", int'(bus.free_cnt), 4);
        force_scan_expect(4);
        ack_victim(1'b1, BW'(4));
        check("ack4_free_cnt", int'(bus.free_cnt), 5);

        // Only the open block is dirty now: scan must fail.
        exp_fail.push_back(1);
        bus.gc_force = 1'b1;
        tick();
        bus.gc_force = 1'b0;
        repeat (20) tick();
        check("fail_idle", int'(bus.gc_busy), 0);
        check("fail_no_victim", int'(bus.victim_valid), 0);

        // FIFO full corners. Contents now 7,3,9,2,4.
        bus.recover_en  = 1'b1;
        bus.recover_blk = BW'(10);
        tick();
        bus.recover_blk = BW'(11);
        tick();
        bus.recover_blk = BW'(13);
        tick();
        bus.recover_en  = 1'b0;
        check("full_free_cnt", int'(bus.free_cnt), 8);
        exp_rerr.push_back(14);
        bus.recover_en  = 1'b1;
        bus.recover_blk = BW'(14);
        tick();
        bus.recover_en  = 1'b0;
        check("full_drop_free_cnt", int'(bus.free_cnt), 8);
        exp_alloc.push_back(7);
        bus.recover_en  = 1'b1;
        bus.alloc_req   = 1'b1;
        tick();
        bus.recover_en  = 1'b0;
        bus.alloc_req   = 1'b0;
        check("full_swap_free_cnt", int'(bus.free_cnt), 8);
        check("full_swap_head", int'(bus.alloc_blk), 3);
        exp_alloc.push_back(3);
        exp_alloc.push_back(9);
        exp_alloc.push_back(2);
        bus.alloc_req = 1'b1;
        repeat (3) tick();
        bus.alloc_req = 1'b0;
        check("pop3_free_cnt", int'(bus.free_cnt), 5);
        check("pop3_head", int'(bus.alloc_blk), 4);

        // Asynchronous reset in the middle of a scan.
        bus.gc_force = 1'b1;
        tick();
        bus.gc_force = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", int'(bus.gc_busy), 1);
        #3;
        nRST = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (5) tick();
        check("uninit_ready", int'(bus.ready), 0);
        check("uninit_alloc_ok", int'(bus.alloc_ok), 0);
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        repeat (8) tick();
        check("reinit_ready", int'(bus.ready), 1);
        check("reinit_free_cnt", int'(bus.free_cnt), 8);
        check("reinit_alloc_blk", int'(bus.alloc_blk), 0);

        check("left_alloc", exp_alloc.size(), 0);
        check("left_victim", exp_victim.size(), 0);
        check("left_rerr", exp_rerr.size(), 0);
        check("left_fail", exp_fail.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
